mcu_compute_core: RTL

Parametrised next-generation computational unit for the MPU341 family datapath. It provides a DATA_W-wide data bus multiplexer, NREG-deep X and Y operand banks, M/I/O registers, and an ALU with carry flag and add-with-carry. Multiplication is sequential shift-add with a busy/done handshake. It sits between the instruction decoder, which drives selects, enables and opcode, and the data memory and I/O pins.

---
 rtl/mcu_compute_core.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mcu_compute_core.sv
// MPU341 computational unit: data bus mux, X/Y operand banks, M/I/O registers,
// single-cycle ALU with carry, and a sequential shift-add multiplier with busy/done.
module mcu_compute_core #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned NREG   = 2,
   parameter int unsigned SEL_W  = (NREG > 2) ? $clog2(NREG) : 1
) (
   input  logic              clk,
   input  logic              async_reset_n,
   input  logic [3:0]        op,
   input  logic              start,
   input  logic [SEL_W-1:0]  x_sel,
   input  logic [SEL_W-1:0]  y_sel,
   input  logic [2:0]        source_sel,
   input  logic [SEL_W-1:0]  src_idx,
   input  logic [NREG-1:0]   x_en,
   input  logic [NREG-1:0]   y_en,
   input  logic              m_en,
   input  logic              o_en,
   input  logic              i_en,
   input  logic              i_sel,
   input  logic [DATA_W-1:0] dm,
   input  logic [DATA_W-1:0] pm_data,
   input  logic [DATA_W-1:0] i_pins,
   output logic [DATA_W-1:0] data_bus,
   output logic [DATA_W-1:0] r,
   output logic [DATA_W-1:0] m,
   output logic [DATA_W-1:0] i,
   output logic [DATA_W-1:0] o_reg,
   output logic              r_eq_0,
   output logic              carry,
   output logic              busy,
   output logic              done
);

   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam int unsigned CNT_W  = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   localparam logic [3:0] OP_NEG = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_ADD = 4'd3;
   localparam logic [3:0] OP_MMS = 4'd4;
   localparam logic [3:0] OP_MLS = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;
   localparam logic [3:0] OP_AND = 4'd7;
   localparam logic [3:0] OP_INV = 4'd8;
   localparam logic [3:0] OP_ADC = 4'd9;
   localparam logic [3:0] OP_SHL = 4'd10;
   localparam logic [3:0] OP_SHR = 4'd11;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t state_q, state_d;

   logic [DATA_W-1:0] x_q [NREG];
   logic [DATA_W-1:0] x_d [NREG];
   logic [DATA_W-1:0] y_q [NREG];
   logic [DATA_W-1:0] y_d [NREG];
   logic [DATA_W-1:0] r_q, r_d, m_q, m_d, i_q, i_d, o_q, o_d;
   logic              r_eq_0_q, r_eq_0_d, carry_q, carry_d, done_q, done_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PROD_W-1:0] mc_q, mc_d, acc_q, acc_d;
   logic [DATA_W-1:0] mp_q, mp_d;
   logic              mul_hi_q, mul_hi_d;

   logic              accept_c, step_c, last_c, is_mul_c;
   logic [DATA_W-1:0] x_opnd_c, y_opnd_c, alu_r_c, mul_res_c;
   logic              alu_cy_c, alu_wr_c;
   logic [DATA_W:0]   add_c, adc_c, sub_c;
   logic [PROD_W-1:0] prod_c;

   assign is_mul_c = (op == OP_MMS) || (op == OP_MLS);

   // State register; async reset also aborts any multiply in flight
   always_ff @(posedge clk or negedge async_reset_n) begin
      if (!async_reset_n) state_q <= S_IDLE;
      else                state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start && is_mul_c) state_d = S_MUL;
         S_MUL:   if (cnt_q == CNT_LAST) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // start is only honoured while idle; nothing is queued during a multiply
   always_comb begin
      accept_c = 1'b0;
      step_c   = 1'b0;
      last_c   = 1'b0;
      case (state_q)
         S_IDLE: accept_c = start;
         S_MUL: begin
            step_c = 1'b1;
            last_c = (cnt_q == CNT_LAST);
         end
         default: ;
      endcase
   end

   always_comb begin
      data_bus = '0;
      case (source_sel)
         3'd0: data_bus = x_q[src_idx];
         3'd1: data_bus = y_q[src_idx];
         3'd2: data_bus = r_q;
         3'd3: data_bus = m_q;
         3'd4: data_bus = i_q;
         3'd5: data_bus = dm;
         3'd6: data_bus = pm_data;
         3'd7: data_bus = i_pins;
         default: data_bus = '0;
      endcase
   end

   // Single-cycle ALU; opcodes without a result fall to the no-write default
   always_comb begin
      x_opnd_c = x_q[x_sel];
      y_opnd_c = y_q[y_sel];
      add_c    = {1'b0, x_opnd_c} + {1'b0, y_opnd_c};
      adc_c    = add_c + (DATA_W+1)'(carry_q);
      sub_c    = {1'b0, x_opnd_c} - {1'b0, y_opnd_c};
      alu_wr_c = 1'b1;
      alu_r_c  = r_q;
      alu_cy_c = 1'b0;
      case (op)
         OP_NEG: begin
            alu_r_c  = DATA_W'(0) - x_opnd_c;
            alu_cy_c = |x_opnd_c;
         end
         OP_SUB:  {alu_cy_c, alu_r_c} = sub_c;
         OP_ADD:  {alu_cy_c, alu_r_c} = add_c;
         OP_ADC:  {alu_cy_c, alu_r_c} = adc_c;
         OP_XOR:  alu_r_c = x_opnd_c ^ y_opnd_c;
         OP_AND:  alu_r_c = x_opnd_c & y_opnd_c;
         OP_INV:  alu_r_c = ~x_opnd_c;
         OP_SHL:  {alu_cy_c, alu_r_c} = {x_opnd_c, 1'b0};
         OP_SHR:  {alu_r_c, alu_cy_c} = {1'b0, x_opnd_c};
         default: begin
            alu_wr_c = 1'b0;
            alu_cy_c = carry_q;
         end
      endcase
   end

   // Register next-state: bank loads, M/I/O, ALU writeback and multiplier steps
   always_comb begin
      x_d      = x_q;
      y_d      = y_q;
      m_d      = m_q;
      i_d      = i_q;
      o_d      = o_q;
      r_d      = r_q;
      r_eq_0_d = r_eq_0_q;
      carry_d  = carry_q;
      done_d   = 1'b0;
      cnt_d    = cnt_q;
      mc_d     = mc_q;
      mp_d     = mp_q;
      acc_d    = acc_q;
      mul_hi_d = mul_hi_q;
      prod_c    = acc_q + (mp_q[0] ? mc_q : '0);
      mul_res_c = mul_hi_q ? prod_c[PROD_W-1:DATA_W] : prod_c[DATA_W-1:0];

      for (int k = 0; k < int'(NREG); k++) begin
         if (x_en[k]) x_d[k] = data_bus;
         if (y_en[k]) y_d[k] = data_bus;
      end
      if (m_en) m_d = data_bus;
      if (o_en) o_d = data_bus;
      if (i_en) i_d = i_sel ? (i_q + m_q) : data_bus;

      if (accept_c && is_mul_c) begin
         mc_d     = PROD_W'(x_opnd_c);
         mp_d     = y_opnd_c;
         acc_d    = '0;
         cnt_d    = '0;
         mul_hi_d = (op == OP_MMS);
      end else if (accept_c) begin
         done_d = 1'b1;
         if (alu_wr_c) begin
            r_d      = alu_r_c;
            carry_d  = alu_cy_c;
            r_eq_0_d = (alu_r_c == '0);
         end
      end

      if (step_c) begin
         acc_d = prod_c;
         mc_d  = mc_q << 1;
         mp_d  = mp_q >> 1;
         cnt_d = cnt_q + CNT_W'(1);
         if (last_c) begin
            r_d      = mul_res_c;
            carry_d  = 1'b0;
            r_eq_0_d = (mul_res_c == '0);
            done_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge async_reset_n) begin
      if (!async_reset_n) begin
         x_q      <= '{default: '0};
         y_q      <= '{default: '0};
         r_q      <= '0;
         m_q      <= '0;
         i_q      <= '0;
         o_q      <= '0;
         r_eq_0_q <= 1'b1;
         carry_q  <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
         mc_q     <= '0;
         mp_q     <= '0;
         acc_q    <= '0;
         mul_hi_q <= 1'b0;
      end else begin
         x_q      <= x_d;
         y_q      <= y_d;
         r_q      <= r_d;
         m_q      <= m_d;
         i_q      <= i_d;
         o_q      <= o_d;
         r_eq_0_q <= r_eq_0_d;
         carry_q  <= carry_d;
         done_q   <= done_d;
         cnt_q    <= cnt_d;
         mc_q     <= mc_d;
         mp_q     <= mp_d;
         acc_q    <= acc_d;
         mul_hi_q <= mul_hi_d;
      end
   end

   assign r      = r_q;
   assign m      = m_q;
   assign i      = i_q;
   assign o_reg  = o_q;
   assign r_eq_0 = r_eq_0_q;
   assign carry  = carry_q;
   assign done   = done_q;
   assign busy   = (state_q == S_MUL);

endmodule
